// File: rtl/axis_fifo_rd_adapter.sv
// Read-side adapter: pops packed words from a 1-cycle-latency FIFO read port and
// presents them on an AXI-Stream master through a 2-entry output buffer.
module axis_fifo_rd_adapter #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned DEST_WIDTH = 8,
    parameter int unsigned USER_WIDTH = 1
) (
    input  logic                                                              clk,
    input  logic                                                              rst_n,
    output logic                                                              fifo_rd_en,
    input  logic [DATA_WIDTH+KEEP_WIDTH+1+ID_WIDTH+DEST_WIDTH+USER_WIDTH-1:0] fifo_data_out,
    input  logic                                                              fifo_empty,
    output logic [DATA_WIDTH-1:0]                                             m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]                                             m_axis_tkeep,
    output logic                                                              m_axis_tvalid,
    input  logic                                                              m_axis_tready,
    output logic                                                              m_axis_tlast,
    output logic [ID_WIDTH-1:0]                                               m_axis_tid,
    output logic [DEST_WIDTH-1:0]                                             m_axis_tdest,
    output logic [USER_WIDTH-1:0]                                             m_axis_tuser,
    output logic [15:0]                                                       frame_count
);

    localparam int unsigned FIFO_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
    localparam int unsigned DEST_LSB   = USER_WIDTH;
    localparam int unsigned ID_LSB     = USER_WIDTH + DEST_WIDTH;
    localparam int unsigned LAST_POS   = USER_WIDTH + DEST_WIDTH + ID_WIDTH;
    localparam int unsigned KEEP_LSB   = LAST_POS + 1;

    logic [1:0]            occ;
    logic [1:0]            occ_next;
    logic                  inflight;
    logic [FIFO_WIDTH-1:0] head_q;
    logic [FIFO_WIDTH-1:0] skid_q;
    logic [FIFO_WIDTH-1:0] head_next;
    logic [FIFO_WIDTH-1:0] skid_next;
    logic                  valid_next;
    logic                  pop;
    logic [2:0]            credit;

    // Credit counts buffered plus in-flight words after this cycle's pop.
    assign pop        = m_axis_tvalid & m_axis_tready;
    assign credit     = 3'(occ) + 3'(inflight) - 3'(pop);
    assign fifo_rd_en = rst_n & ~fifo_empty & (credit < 3'd2);

    // Buffer next state: captured word goes to the tail, skid shifts to head on pop.
    always_comb begin
        head_next = head_q;
        skid_next = skid_q;
        occ_next  = occ;
        case (occ)
            2'd0: begin
                if (inflight) begin
                    head_next = fifo_data_out;
                    occ_next  = 2'd1;
                end
            end
            2'd1: begin
                case ({inflight, pop})
                    2'b11: head_next = fifo_data_out;
                    2'b10: begin
                        skid_next = fifo_data_out;
                        occ_next  = 2'd2;
                    end
                    2'b01: occ_next = 2'd0;
                    default: ;
                endcase
            end
            2'd2: begin
                if (pop) begin
                    head_next = skid_q;
                    if (inflight) begin
                        skid_next = fifo_data_out;
                    end else begin
                        occ_next = 2'd1;
                    end
                end
            end
            default: occ_next = 2'd0;
        endcase
        valid_next = (occ_next != 2'd0);
    end

    // State and registered stream outputs; payload fields are masked while idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ           <= 2'd0;
            inflight      <= 1'b0;
            head_q        <= '0;
            skid_q        <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tid    <= '0;
            m_axis_tdest  <= '0;
            m_axis_tuser  <= '0;
            frame_count   <= 16'd0;
        end else begin
            occ           <= occ_next;
            inflight      <= fifo_rd_en;
            head_q        <= head_next;
            skid_q        <= skid_next;
            m_axis_tvalid <= valid_next;
            m_axis_tdata  <= valid_next ? head_next[FIFO_WIDTH-1 -: DATA_WIDTH] : '0;
            m_axis_tkeep  <= valid_next ? head_next[KEEP_LSB +: KEEP_WIDTH] : '0;
            m_axis_tlast  <= valid_next & head_next[LAST_POS];
            m_axis_tid    <= head_next[ID_LSB +: ID_WIDTH];
            m_axis_tdest  <= head_next[DEST_LSB +: DEST_WIDTH];
            m_axis_tuser  <= head_next[USER_WIDTH-1:0];
            if (pop && m_axis_tlast) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_axis_fifo_rd_adapter.sv
// Bench for axis_fifo_rd_adapter: FIFO read-port model feeding a scoreboard of expected beats.
module tb_axis_fifo_rd_adapter;

    localparam int FW = 64 + 8 + 1 + 8 + 8 + 1;

    typedef struct packed {
        logic [63:0] tdata;
        logic [7:0]  tkeep;
        logic        tlast;
        logic [7:0]  tid;
        logic [7:0]  tdest;
        logic [0:0]  tuser;
    } beat_t;

    typedef struct {
        beat_t in_word;
        beat_t exp_out;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_rd_en;
    logic [FW-1:0] fifo_data_out = '0;
    logic          fifo_empty = 1'b1;
    logic [63:0]   m_axis_tdata;
    logic [7:0]    m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tlast;
    logic [7:0]    m_axis_tid;
    logic [7:0]    m_axis_tdest;
    logic [0:0]    m_axis_tuser;
    logic [15:0]   frame_count;

    axis_fifo_rd_adapter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_data_out(fifo_data_out),
        .fifo_empty   (fifo_empty),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tid   (m_axis_tid),
        .m_axis_tdest (m_axis_tdest),
        .m_axis_tuser (m_axis_tuser),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    vec_t        src_q[$];
    beat_t       exp_q[$];
    vec_t        tbl[16];
    int          cyc = 0;
    int          rd_cnt, beat_cnt, first_rd, first_beat, last_beat;
    int          outstanding = 0;
    logic [15:0] exp_frames = 16'd0;
    logic        prev_stall = 1'b0;
    beat_t       prev_obs;
    bit          ready_rand = 0, empty_rand = 0, ready_val = 1, force_nonempty = 0;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t rand_word(input logic last);
        beat_t b;
        b.tdata = {$urandom(), $urandom()};
        b.tkeep = 8'($urandom());
        b.tlast = last;
        b.tid   = 8'($urandom());
        b.tdest = 8'($urandom());
        b.tuser = 1'($urandom());
        return b;
    endfunction

    task automatic push(input beat_t w, input beat_t e);
        vec_t v;
        v.in_word = w;
        v.exp_out = e;
        src_q.push_back(v);
    endtask

    task automatic drive();
        m_axis_tready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
        if (force_nonempty)
            fifo_empty = 1'b0;
        else
            fifo_empty = (src_q.size() == 0) || (empty_rand && ($urandom_range(0, 1) == 0));
    endtask

    task automatic clear_stats();
        rd_cnt = 0; beat_cnt = 0; first_rd = -1; first_beat = -1; last_beat = -1;
    endtask

    // One clock: sample at negedge, then model FIFO and scoreboard after the edge.
    task automatic tick();
        logic  rd, v, r;
        beat_t obs;
        beat_t e;
        vec_t  sv;
        @(negedge clk);
        rd = fifo_rd_en;
        v  = m_axis_tvalid;
        r  = m_axis_tready;
        obs.tdata = m_axis_tdata;
        obs.tkeep = m_axis_tkeep;
        obs.tlast = m_axis_tlast;
        obs.tid   = m_axis_tid;
        obs.tdest = m_axis_tdest;
        obs.tuser = m_axis_tuser;
        if (!v) check("idle_zero", FW'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), FW'(0));
        if (prev_stall) begin
            check("stall_valid", FW'(v), FW'(1));
            check("stall_hold", obs, prev_obs);
        end
        check("frame_count", FW'(frame_count), FW'(exp_frames));
        prev_stall = v & ~r;
        prev_obs   = obs;
        if (rd) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (v && r) begin
            beat_cnt++;
            if (first_beat < 0) first_beat = cyc;
            last_beat = cyc;
        end
        @(posedge clk);
        #1;
        if (rd) begin
            if (src_q.size() == 0) begin
                check("pop_from_empty", FW'(1), FW'(0));
            end else begin
                sv = src_q.pop_front();
                fifo_data_out = sv.in_word;
                exp_q.push_back(sv.exp_out);
                outstanding++;
            end
        end
        if (v && r) begin
            outstanding--;
            if (exp_q.size() == 0) begin
                check("unexpected_beat", obs, FW'(0));
            end else begin
                e = exp_q.pop_front();
                check("beat", obs, e);
                if (e.tlast) exp_frames = exp_frames + 16'd1;
            end
        end
        check("inflight_le2", FW'(outstanding > 2), FW'(0));
        cyc++;
        drive();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        if (src_q.size() != 0 || exp_q.size() != 0)
            check("drain_timeout", FW'(exp_q.size() + src_q.size()), FW'(0));
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        force_nonempty = 1;
        drive();
        @(posedge clk);
        #1;
        exp_frames  = 16'd0;
        outstanding = 0;
        prev_stall  = 1'b0;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            tick();
            check("rst_rd_en", FW'(fifo_rd_en), FW'(0));
            check("rst_tvalid", FW'(m_axis_tvalid), FW'(0));
            check("rst_tdata", FW'(m_axis_tdata), FW'(0));
            check("rst_frame_count", FW'(frame_count), FW'(0));
        end
        rst_n = 1'b1;
        force_nonempty = 0;
        drive();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t w;
        int    base;

        // Vector table: entry 0 is the reference word, the rest are patterned.
        tbl[0].in_word = '{tdata: 64'hA5A5_0000_1234_5678, tkeep: 8'hFF, tlast: 1'b1,
                           tid: 8'd3, tdest: 8'd7, tuser: 1'b1};
        tbl[0].exp_out = '{tdata: 64'hA5A5_0000_1234_5678, tkeep: 8'hFF, tlast: 1'b1,
                           tid: 8'd3, tdest: 8'd7, tuser: 1'b1};
        for (int i = 1; i < 16; i++) begin
            w.tdata = {32'hC0DE_0000 | 32'(i), ~32'(i)};
            w.tkeep = 8'((1 << (i % 8 + 1)) - 1);
            w.tlast = 1'((i % 4) == 3);
            w.tid   = 8'(i);
            w.tdest = 8'(8'hF0 - 8'(i));
            w.tuser = 1'(i);
            tbl[i].in_word = w;
            tbl[i].exp_out = w;
        end

        // 1: reset held with FIFO non-empty.
        do_reset(3);

        // 2: single word latency and field mapping.
        clear_stats();
        push(tbl[0].in_word, tbl[0].exp_out);
        drive();
        drain(20);
        for (int i = 0; i < 3; i++) tick();
        check("t2_rd_cnt", FW'(rd_cnt), FW'(1));
        check("t2_latency", FW'(first_beat - first_rd), FW'(2));
        check("t2_frames", FW'(frame_count), FW'(1));

        // 3: 16 back-to-back words at full throughput.
        clear_stats();
        for (int i = 0; i < 16; i++) push(tbl[i].in_word, tbl[i].exp_out);
        drive();
        drain(60);
        check("t3_beats", FW'(beat_cnt), FW'(16));
        check("t3_latency", FW'(first_beat - first_rd), FW'(2));
        check("t3_back_to_back", FW'(last_beat - first_beat), FW'(15));

        // 4: 10-cycle backpressure mid-stream.
        clear_stats();
        for (int i = 0; i < 24; i++) begin
            w = rand_word(1'(i % 3 == 2));
            push(w, w);
        end
        drive();
        for (int i = 0; i < 6; i++) tick();
        ready_val = 0;
        drive();
        base = rd_cnt;
        for (int i = 0; i < 10; i++) tick();
        check("t4_stall_pops_le2", FW'((rd_cnt - base) > 2), FW'(0));
        ready_val = 1;
        drive();
        drain(100);
        check("t4_beats", FW'(beat_cnt), FW'(24));

        // 5: random empty and ready.
        clear_stats();
        for (int i = 0; i < 2000; i++) begin
            w = rand_word(1'($urandom()));
            push(w, w);
        end
        ready_rand = 1;
        empty_rand = 1;
        drive();
        drain(30000);
        ready_rand = 0;
        empty_rand = 0;
        drive();
        check("t5_beats", FW'(beat_cnt), FW'(2000));

        // 6: frame counter wrap.
        do_reset(2);
        clear_stats();
        for (int i = 0; i < 65536; i++) begin
            w = rand_word(1'b1);
            push(w, w);
        end
        drive();
        drain(70000);
        @(negedge clk);
        check("t6_wrap", FW'(frame_count), FW'(16'd0));
        #1;
        w = rand_word(1'b1);
        push(w, w);
        @(posedge clk);
        #1;
        drive();
        drain(20);
        @(negedge clk);
        check("t6_after_wrap", FW'(frame_count), FW'(16'd1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
